// File: rtl/vga_frame_capture.sv
// vga_frame_capture
//
// Receive end of the VGA pixel interface. Once armed by start, it waits for
// the next vertical sync fall and then writes one full active frame of 8-bit
// pixels, row-major, into a RAM write port. It also checks the frame geometry:
// the length of every active line, the number of active lines per frame, and
// pixels that arrive beyond the frame size.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active low
//   pix_en     one-clk pixel strobe; video inputs are sampled only when high
//   h_sync     horizontal sync, active low (not used for capture)
//   v_sync     vertical sync, active low
//   blank_n    high during active video
//   pix        8-bit pixel data
//   start      one-clk pulse; arms capture of the next full frame
//   abort      one-clk pulse; abandons the capture and returns to idle
//   busy       high while waiting for the frame start or capturing
//   done       high once a frame has completed, until the next accepted start
//   wr_en      RAM write strobe, one clk wide
//   wr_addr    RAM write address, 0 = top-left pixel
//   wr_data    RAM write data
//   line_cnt   active lines completed in the current or last frame
//   err_line   sticky: an active line had the wrong length
//   err_frame  sticky: the wrong number of active lines at frame end
//   err_ovf    sticky: an active pixel arrived after the frame was full

module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              blank_n,
  input  logic [7:0]        pix,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [9:0]        line_cnt,
  output logic              err_line,
  output logic              err_frame,
  output logic              err_ovf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;

  // The write counter carries one extra bit so that a frame that exactly
  // fills the address space can still represent "full".
  localparam logic [ADDR_W:0] WR_FULL = (ADDR_W + 1)'(TOTAL);

  // The line pixel counter has headroom above H_ACTIVE so overlong lines are
  // still seen as wrong; it saturates instead of wrapping.
  localparam int PCW = $clog2(H_ACTIVE + 2) + 1;
  localparam logic [PCW-1:0] PC_H   = PCW'(H_ACTIVE);
  localparam logic [PCW-1:0] PC_MAX = '1;

  localparam logic [9:0] LINES_EXP = 10'(V_ACTIVE);
  localparam logic [9:0] LINES_MAX = 10'h3FF;

  logic [1:0]     state;
  logic           vs_q;
  logic           bl_q;
  logic [PCW-1:0] pix_cnt;
  logic [ADDR_W:0] wr_cnt;

  logic           fb;
  logic           eol;
  logic           act;
  logic [9:0]     line_cnt_n;

  // h_sync plays no part in capture; this sink only keeps lint quiet.
  logic unused_hs;
  assign unused_hs = h_sync;

  // Edges are judged between successive strobed samples, never between clks.
  assign fb  = pix_en & vs_q & ~v_sync;
  assign eol = pix_en & bl_q & ~blank_n;
  assign act = pix_en & blank_n;

  // Line count including an end-of-line in the current sample, so a frame
  // boundary arriving together with the last eol still sees the full count.
  always_comb begin
    line_cnt_n = line_cnt;
    if (eol && line_cnt != LINES_MAX) line_cnt_n = line_cnt + 10'd1;
  end

  assign busy    = (state == S_WAIT_VS) || (state == S_CAPTURE);
  assign done    = (state == S_DONE);
  assign wr_addr = wr_cnt[ADDR_W-1:0];

  // The address is advanced on the clk after the write strobe, so wr_addr
  // shows the address being written while wr_en is high. This relies on
  // pix_en never being asserted on two consecutive clks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      vs_q      <= 1'b0;
      bl_q      <= 1'b0;
      pix_cnt   <= '0;
      wr_cnt    <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      line_cnt  <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      if (pix_en) begin
        vs_q <= v_sync;
        bl_q <= blank_n;
      end

      if (wr_en && wr_cnt != WR_FULL) wr_cnt <= wr_cnt + (ADDR_W + 1)'(1);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WAIT_VS;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
            err_ovf   <= 1'b0;
            line_cnt  <= '0;
            wr_cnt    <= '0;
            pix_cnt   <= '0;
          end
        end

        S_WAIT_VS: begin
          if (abort)   state <= S_IDLE;
          else if (fb) state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            if (act) begin
              if (wr_cnt < WR_FULL) begin
                wr_en   <= 1'b1;
                wr_data <= pix;
              end else begin
                err_ovf <= 1'b1;
              end
              if (pix_cnt != PC_MAX) pix_cnt <= pix_cnt + PCW'(1);
            end
            if (eol) begin
              line_cnt <= line_cnt_n;
              if (pix_cnt != PC_H) err_line <= 1'b1;
              pix_cnt <= '0;
            end
            if (fb) begin
              state <= S_DONE;
              if (line_cnt_n != LINES_EXP) err_frame <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
